// File: rtl/falcon_pkg.sv
// Shared definitions for the small-polynomial gather logic: FSM state
// encoding, coefficient bound and coefficient / counter widths.
package falcon_pkg;

    localparam int unsigned COEF_W     = 8;
    localparam int          COEF_BOUND = 127;
    localparam int unsigned VAL_W      = 32;
    localparam int unsigned REJ_W      = 16;
    localparam int unsigned NORM_W     = 32;
    localparam int unsigned PROD_W     = 2 * COEF_W;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/small_coef_check.sv
// Combinational classification of one Gaussian sample.
//   val         : signed 32-bit sample
//   in_range_c  : -COEF_BOUND <= val <= COEF_BOUND
//   par_c       : low bit of the sample (parity contribution)
//   coef_c      : sample truncated to an 8-bit two's-complement coefficient
module small_coef_check
    import falcon_pkg::*;
(
    input  logic [VAL_W-1:0]  val,
    output logic              in_range_c,
    output logic              par_c,
    output logic [COEF_W-1:0] coef_c
);

    assign in_range_c = ($signed(val) >= -COEF_BOUND) && ($signed(val) <= COEF_BOUND);
    assign par_c      = val[0];
    // Exact for in-range samples; out-of-range samples are never written.
    assign coef_c     = val[COEF_W-1:0];

endmodule

// File: rtl/poly_small_gather.sv
// Collects N = 2^LOGN small signed coefficients from a Gaussian sampler
// stream, rejecting out-of-range samples and forcing an odd coefficient sum
// via the last coefficient. Accepted coefficients are written to a
// coefficient RAM through a registered write port.
//
// Optional feature: define POLY_SMALL_NORM_EN to accumulate the squared norm
// of the accepted coefficients; otherwise sq_norm is tied to zero.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request to collect a polynomial (IDLE only)
//   val_valid, val  Gaussian sample stream, no backpressure
//   gauss_req       keep-producing request to the sampler (equals busy)
//   coef_we/addr/data  registered coefficient RAM write port
//   busy            high while collecting
//   done            pulse together with the write of coefficient N-1
//   rej_cnt         rejected samples in this polynomial, saturating
//   sq_norm         sum of squares of accepted coefficients
module poly_small_gather
    import falcon_pkg::*;
#(
    parameter int unsigned LOGN = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              val_valid,
    input  logic [31:0]       val,
    output logic              gauss_req,
    output logic              coef_we,
    output logic [LOGN-1:0]   coef_addr,
    output logic [7:0]        coef_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       rej_cnt,
    output logic [31:0]       sq_norm
);

    state_t              state, state_nxt;
    logic [LOGN-1:0]     idx, idx_nxt;
    logic                parity, parity_nxt;
    logic                we_nxt;
    logic [LOGN-1:0]     addr_nxt;
    logic [COEF_W-1:0]   data_nxt;
    logic                done_nxt;
    logic                busy_nxt;
    logic [REJ_W-1:0]    rej_nxt;

    logic                in_range_c;
    logic                par_c;
    logic [COEF_W-1:0]   coef_c;
    logic                last_c;
    logic                accept_c;

`ifdef POLY_SMALL_NORM_EN
    logic [NORM_W-1:0]        sq_q, sq_nxt;
    logic signed [PROD_W-1:0] prod_c;
`endif

    small_coef_check u_check (
        .val        (val),
        .in_range_c (in_range_c),
        .par_c      (par_c),
        .coef_c     (coef_c)
    );

    // The final coefficient must make the running coefficient sum odd.
    assign last_c   = (idx == {LOGN{1'b1}});
    assign accept_c = in_range_c && (!last_c || (parity ^ par_c));

`ifdef POLY_SMALL_NORM_EN
    assign prod_c = $signed(coef_c) * $signed(coef_c);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        parity_nxt = parity;
        we_nxt     = 1'b0;
        addr_nxt   = coef_addr;
        data_nxt   = coef_data;
        done_nxt   = 1'b0;
        rej_nxt    = rej_cnt;
`ifdef POLY_SMALL_NORM_EN
        sq_nxt     = sq_q;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_COLLECT;
                    idx_nxt    = '0;
                    parity_nxt = 1'b0;
                    rej_nxt    = '0;
`ifdef POLY_SMALL_NORM_EN
                    sq_nxt     = '0;
`endif
                end
            end
            ST_COLLECT: begin
                if (val_valid) begin
                    if (accept_c) begin
                        we_nxt     = 1'b1;
                        addr_nxt   = idx;
                        data_nxt   = coef_c;
                        parity_nxt = parity ^ par_c;
                        idx_nxt    = idx + LOGN'(1);
`ifdef POLY_SMALL_NORM_EN
                        sq_nxt     = sq_q + NORM_W'($unsigned(prod_c));
`endif
                        if (last_c) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end else if (rej_cnt != {REJ_W{1'b1}}) begin
                        rej_nxt = rej_cnt + REJ_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == ST_COLLECT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            parity    <= 1'b0;
            coef_we   <= 1'b0;
            coef_addr <= '0;
            coef_data <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rej_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            parity    <= parity_nxt;
            coef_we   <= we_nxt;
            coef_addr <= addr_nxt;
            coef_data <= data_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            rej_cnt   <= rej_nxt;
        end
    end

`ifdef POLY_SMALL_NORM_EN
    // Squared-norm accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_nxt;
        end
    end
    assign sq_norm = sq_q;
`else
    assign sq_norm = '0;
`endif

    assign gauss_req = busy;

endmodule
